// File: rtl/axi_arb_pkg.sv
// Shared types and defaults for the AXI address-channel arbiters.
package axi_arb_pkg;

  localparam int ARB_ID_W    = 4;
  localparam int ARB_ADDR_W  = 32;
  localparam int ARB_LEN_W   = 4;
  localparam int ARB_SIZE_W  = 3;
  localparam int ARB_BURST_W = 2;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

endpackage : axi_arb_pkg

// File: rtl/rr_priority_picker.sv
// Combinational winner selection: highest set index in fixed mode, or the
// first set index at or after ptr (wrapping at N-1) in round-robin mode.
module rr_priority_picker
  import axi_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          mode,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic found;
  int   c;

  // Scan candidates in priority order; wrap is done against N, not 2**PW.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    c     = 0;
    if (mode == ARB_RR) begin
      for (int i = 0; i < N; i++) begin
        c = int'(ptr) + i;
        if (c >= N) c = c - N;
        for (int j = 0; j < N; j++) begin
          if (!found && (j == c) && req[j]) begin
            idx   = PW'(j);
            found = 1'b1;
          end
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) idx = PW'(i);
      end
    end
  end

  assign any = |req;

endmodule : rr_priority_picker

// File: rtl/axi_addr_arbiter_rr.sv
// N-master arbiter for one AXI address channel. Holds a grant until the
// address handshake, then re-arbitrates in the same cycle (no bubble).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | no grant held; outputs zero; any request is granted next
// ARB_GRANT | master g owns the channel until VALID&READY or VALID drops
module axi_addr_arbiter_rr
  import axi_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ID_W        = ARB_ID_W,
  parameter int ADDR_W      = ARB_ADDR_W,
  parameter int LEN_W       = ARB_LEN_W,
  parameter int SIZE_W      = ARB_SIZE_W,
  parameter int RR_MODE     = 1,
  parameter int MIDX_W      = $clog2(NUM_MASTERS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ID_W-1:0]       ID_in,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     ADDR_in,
  input  logic [NUM_MASTERS*LEN_W-1:0]      LEN_in,
  input  logic [NUM_MASTERS*SIZE_W-1:0]     SIZE_in,
  input  logic [NUM_MASTERS*ARB_BURST_W-1:0] BURST_in,
  input  logic [NUM_MASTERS-1:0]            VALID_in,
  output logic [NUM_MASTERS-1:0]            READY_out,
  input  logic                              READY,
  output logic [ID_W-1:0]                   ID,
  output logic [ADDR_W-1:0]                 ADDR,
  output logic [LEN_W-1:0]                  LEN,
  output logic [SIZE_W-1:0]                 SIZE,
  output logic [ARB_BURST_W-1:0]            BURST,
  output logic                              VALID,
  output logic [MIDX_W-1:0]                 Master,
  output logic                              grant_active
);

  arb_state_t        state;
  logic [MIDX_W-1:0] g;
  logic [MIDX_W-1:0] rr_ptr;
  logic [MIDX_W-1:0] next_ptr;
  logic [MIDX_W-1:0] pick_ptr;
  logic [MIDX_W-1:0] win;
  logic              win_any;
  logic              granted;
  logic              g_valid;
  logic              handshake;

  // Reset gates the grant in the same cycle so no handshake can slip through.
  assign granted   = (state == ARB_GRANT) && !rst;
  assign handshake = granted && g_valid && READY;
  assign next_ptr  = (g == MIDX_W'(NUM_MASTERS - 1)) ? '0 : g + 1'b1;
  assign pick_ptr  = handshake ? next_ptr : rr_ptr;

  rr_priority_picker #(
    .N  (NUM_MASTERS),
    .PW (MIDX_W)
  ) u_pick (
    .req  (VALID_in),
    .ptr  (pick_ptr),
    .mode ((RR_MODE != 0) ? ARB_RR : ARB_FIXED),
    .idx  (win),
    .any  (win_any)
  );

  // Channel mux: only the granted slice ever reaches the outputs.
  always_comb begin
    g_valid   = 1'b0;
    ID        = '0;
    ADDR      = '0;
    LEN       = '0;
    SIZE      = '0;
    BURST     = '0;
    READY_out = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (g == MIDX_W'(k)) begin
        g_valid = VALID_in[k];
        if (granted) begin
          ID           = ID_in[k*ID_W +: ID_W];
          ADDR         = ADDR_in[k*ADDR_W +: ADDR_W];
          LEN          = LEN_in[k*LEN_W +: LEN_W];
          SIZE         = SIZE_in[k*SIZE_W +: SIZE_W];
          BURST        = BURST_in[k*ARB_BURST_W +: ARB_BURST_W];
          READY_out[k] = READY & VALID_in[k];
        end
      end
    end
    VALID        = granted & g_valid;
    Master       = granted ? g : '0;
    grant_active = granted;
  end

  // Grant FSM: register winner, hold until handshake or VALID withdrawal.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      g      <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (win_any) begin
            g     <= win;
            state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (handshake) begin
            if (RR_MODE != 0) rr_ptr <= next_ptr;
            if (win_any) g <= win;
            else         state <= ARB_IDLE;
          end else if (!g_valid) begin
            // Master withdrew VALID without a handshake; pointer untouched.
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule : axi_addr_arbiter_rr

// File: tb/tb_axi_addr_arbiter_rr.sv
// Directed bench for axi_addr_arbiter_rr: RR and fixed N=4 instances plus
// an N=3 RR instance for the non-power-of-two wrap.
module tb_axi_addr_arbiter_rr;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*4-1:0]  id_in;
  logic [N*32-1:0] addr_in;
  logic [N*4-1:0]  len_in;
  logic [N*3-1:0]  size_in;
  logic [N*2-1:0]  burst_in;
  logic [N-1:0]    valid_in;
  logic            ready;

  logic [N-1:0] r_ready_out, f_ready_out;
  logic [3:0]   r_id, f_id;
  logic [31:0]  r_addr, f_addr;
  logic [3:0]   r_len, f_len;
  logic [2:0]   r_size, f_size;
  logic [1:0]   r_burst, f_burst;
  logic         r_valid, f_valid;
  logic [1:0]   r_master, f_master;
  logic         r_ga, f_ga;

  logic [11:0] n_id_in;
  logic [95:0] n_addr_in;
  logic [11:0] n_len_in;
  logic [8:0]  n_size_in;
  logic [5:0]  n_burst_in;
  logic [2:0]  n_valid_in;
  logic        n_ready;
  logic [2:0]  n_ready_out;
  logic [3:0]  n_id;
  logic [31:0] n_addr;
  logic [3:0]  n_len;
  logic [2:0]  n_size;
  logic [1:0]  n_burst;
  logic        n_valid;
  logic [1:0]  n_master;
  logic        n_ga;

  int n_checks = 0;
  int n_errors = 0;

  axi_addr_arbiter_rr #(.NUM_MASTERS(N), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .ID_in(id_in), .ADDR_in(addr_in), .LEN_in(len_in),
    .SIZE_in(size_in), .BURST_in(burst_in), .VALID_in(valid_in),
    .READY_out(r_ready_out), .READY(ready), .ID(r_id), .ADDR(r_addr),
    .LEN(r_len), .SIZE(r_size), .BURST(r_burst), .VALID(r_valid),
    .Master(r_master), .grant_active(r_ga)
  );

  axi_addr_arbiter_rr #(.NUM_MASTERS(N), .RR_MODE(0)) u_fx (
    .clk(clk), .rst(rst), .ID_in(id_in), .ADDR_in(addr_in), .LEN_in(len_in),
    .SIZE_in(size_in), .BURST_in(burst_in), .VALID_in(valid_in),
    .READY_out(f_ready_out), .READY(ready), .ID(f_id), .ADDR(f_addr),
    .LEN(f_len), .SIZE(f_size), .BURST(f_burst), .VALID(f_valid),
    .Master(f_master), .grant_active(f_ga)
  );

  axi_addr_arbiter_rr #(.NUM_MASTERS(3), .RR_MODE(1)) u_n3 (
    .clk(clk), .rst(rst), .ID_in(n_id_in), .ADDR_in(n_addr_in),
    .LEN_in(n_len_in), .SIZE_in(n_size_in), .BURST_in(n_burst_in),
    .VALID_in(n_valid_in), .READY_out(n_ready_out), .READY(n_ready),
    .ID(n_id), .ADDR(n_addr), .LEN(n_len), .SIZE(n_size), .BURST(n_burst),
    .VALID(n_valid), .Master(n_master), .grant_active(n_ga)
  );

  function automatic logic [31:0] exp_addr(int k);
    return 32'h1000_0000 + 32'(k) * 32'h100;
  endfunction
  function automatic logic [31:0] exp_addr3(int k);
    return 32'h2000_0000 + 32'(k);
  endfunction
  function automatic logic [3:0] exp_id(int k);
    return 4'(10 + k);
  endfunction
  function automatic logic [3:0] exp_len(int k);
    return 4'(k + 3);
  endfunction
  function automatic logic [2:0] exp_size(int k);
    return 3'(k + 1);
  endfunction
  function automatic logic [1:0] exp_burst(int k);
    return 2'(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      id_in[k*4 +: 4]     = exp_id(k);
      addr_in[k*32 +: 32] = exp_addr(k);
      len_in[k*4 +: 4]    = exp_len(k);
      size_in[k*3 +: 3]   = exp_size(k);
      burst_in[k*2 +: 2]  = exp_burst(k);
    end
    for (int k = 0; k < 3; k++) begin
      n_id_in[k*4 +: 4]     = exp_id(k);
      n_addr_in[k*32 +: 32] = exp_addr3(k);
      n_len_in[k*4 +: 4]    = exp_len(k);
      n_size_in[k*3 +: 3]   = exp_size(k);
      n_burst_in[k*2 +: 2]  = exp_burst(k);
    end
    n_valid_in = '0;
    n_ready    = 1'b0;

    // Reset with all masters requesting
    valid_in = 4'b1111;
    ready    = 1'b0;
    rst      = 1'b1;
    cyc();
    cyc();
    #1;
    chk("rst_valid",  64'(r_valid), 64'd0);
    chk("rst_ga",     64'(r_ga), 64'd0);
    chk("rst_master", 64'(r_master), 64'd0);
    chk("rst_addr",   64'(r_addr), 64'd0);
    chk("rst_ready_out", 64'(r_ready_out), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_valid", 64'(r_valid), 64'd0);
    cyc();
    chk("first_master", 64'(r_master), 64'd0);
    chk("first_valid",  64'(r_valid), 64'd1);
    chk("first_ga",     64'(r_ga), 64'd1);
    chk("first_addr",   64'(r_addr), 64'(exp_addr(0)));
    chk("first_rdy_out", 64'(r_ready_out), 64'd0);

    // Round-robin rotation with everyone requesting
    ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("rr_master",   64'(r_master), 64'(i % 4));
      chk("rr_ready_out", 64'(r_ready_out), 64'(1) << (i % 4));
      chk("rr_addr",     64'(r_addr), 64'(exp_addr(i % 4)));
      chk("rr_id",       64'(r_id), 64'(exp_id(i % 4)));
      chk("rr_len",      64'(r_len), 64'(exp_len(i % 4)));
      chk("rr_size",     64'(r_size), 64'(exp_size(i % 4)));
      chk("rr_burst",    64'(r_burst), 64'(exp_burst(i % 4)));
      cyc();
    end

    // Fixed priority: master 2 beats master 0 every time
    rst      = 1'b1;
    valid_in = 4'b0101;
    cyc();
    rst = 1'b0;
    cyc();
    #1;
    chk("fx_id",    64'(f_id), 64'(exp_id(2)));
    chk("fx_len",   64'(f_len), 64'(exp_len(2)));
    chk("fx_size",  64'(f_size), 64'(exp_size(2)));
    chk("fx_burst", 64'(f_burst), 64'(exp_burst(2)));
    for (int i = 0; i < 4; i++) begin
      chk("fx_master",    64'(f_master), 64'd2);
      chk("fx_ready_out", 64'(f_ready_out), 64'b0100);
      chk("fx_addr",      64'(f_addr), 64'(exp_addr(2)));
      chk("fx_valid",     64'({f_valid, f_ga}), 64'b11);
      cyc();
    end

    // Hold on M1 with READY low while M3 starts requesting
    rst      = 1'b1;
    valid_in = 4'b0010;
    ready    = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) valid_in = 4'b1010;
      #1;
      chk("hold_master",    64'(r_master), 64'd1);
      chk("hold_addr",      64'(r_addr), 64'(exp_addr(1)));
      chk("hold_ready_out", 64'(r_ready_out), 64'd0);
      cyc();
    end
    ready = 1'b1;
    #1;
    chk("hold_release", 64'(r_ready_out), 64'b0010);
    cyc();
    valid_in = 4'b1000;
    #1;
    chk("after_hold_master", 64'(r_master), 64'd3);
    chk("after_hold_addr",   64'(r_addr), 64'(exp_addr(3)));
    chk("after_hold_rdy",    64'(r_ready_out), 64'b1000);

    // Granted M2 withdraws VALID; pointer must stay at 2
    rst      = 1'b1;
    valid_in = 4'b0010;
    ready    = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    valid_in = 4'b0110;
    #1;
    chk("wd_m1_master", 64'(r_master), 64'd1);
    chk("wd_m1_rdy",    64'(r_ready_out), 64'b0010);
    cyc();
    valid_in = 4'b0100;
    ready    = 1'b0;
    #1;
    chk("wd_m2_master", 64'(r_master), 64'd2);
    chk("wd_m2_valid",  64'(r_valid), 64'd1);
    cyc();
    valid_in = 4'b0000;
    #1;
    chk("wd_drop_valid", 64'(r_valid), 64'd0);
    chk("wd_drop_ga",    64'(r_ga), 64'd1);
    cyc();
    #1;
    chk("wd_idle_ga",    64'(r_ga), 64'd0);
    chk("wd_idle_valid", 64'(r_valid), 64'd0);
    valid_in = 4'b1111;
    cyc();
    #1;
    chk("wd_ptr_kept", 64'(r_master), 64'd2);

    // Reset in the middle of a grant with READY high
    ready = 1'b1;
    rst   = 1'b1;
    #1;
    chk("mid_rst_rdy",    64'(r_ready_out), 64'd0);
    chk("mid_rst_valid",  64'(r_valid), 64'd0);
    chk("mid_rst_ga",     64'(r_ga), 64'd0);
    chk("mid_rst_master", 64'(r_master), 64'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_idle", 64'(r_ga), 64'd0);
    cyc();
    #1;
    chk("mid_rst_regrant", 64'(r_master), 64'd0);

    // Three-master wrap 2 -> 0
    n_valid_in = 3'b111;
    n_ready    = 1'b1;
    rst        = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    #1;
    chk("n3_len",   64'(n_len), 64'(exp_len(0)));
    chk("n3_size",  64'(n_size), 64'(exp_size(0)));
    chk("n3_burst", 64'(n_burst), 64'(exp_burst(0)));
    for (int i = 0; i < 6; i++) begin
      chk("n3_master",    64'(n_master), 64'(i % 3));
      chk("n3_ready_out", 64'(n_ready_out), 64'(1) << (i % 3));
      chk("n3_addr",      64'(n_addr), 64'(exp_addr3(i % 3)));
      chk("n3_id",        64'(n_id), 64'(exp_id(i % 3)));
      chk("n3_vg",        64'({n_valid, n_ga}), 64'b11);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_axi_addr_arbiter_rr

// File: doc/axi_addr_arbiter_rr.md
Name: axi_addr_arbiter_rr

Overview:
- Parametrised N-master arbiter for one AXI address channel (AR or AW), placed in the AXI bridge between the master ports and the slave decoder.
- Selects one requesting master and holds the grant until its address handshake completes.
- Supports fixed-priority and round-robin modes, with back-to-back grants and no idle bubble.
- Forwards the winner's ID, ADDR, LEN, SIZE, BURST and VALID, plus its master index.

Parameters:
- NUM_MASTERS, 4, number of master ports (2..8).
- ID_W, 4, AXI ID width.
- ADDR_W, 32, address width.
- LEN_W, 4, burst length width.
- SIZE_W, 3, burst size width.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (highest index wins).
- MIDX_W, $clog2(NUM_MASTERS), width of master index.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ID_in  in  NUM_MASTERS*ID_W  packed per-master ID; master k occupies slice k.
- ADDR_in  in  NUM_MASTERS*ADDR_W  per-master address.
- LEN_in  in  NUM_MASTERS*LEN_W  per-master burst length.
- SIZE_in  in  NUM_MASTERS*SIZE_W  per-master burst size.
- BURST_in  in  NUM_MASTERS*2  per-master burst type.
- VALID_in  in  NUM_MASTERS  per-master address valid.
- READY_out  out  NUM_MASTERS  per-master address ready.
- READY  in  1  ready from the downstream slave side.
- ID, ADDR, LEN, SIZE, BURST  out  ID_W/ADDR_W/LEN_W/SIZE_W/2  muxed channel of the granted master.
- VALID  out  1  muxed valid.
- Master  out  MIDX_W  index of the granted master.
- grant_active  out  1  high while a grant is held.

Behaviour:
- Reset: on the rising edge with rst=1, the block enters IDLE and rr_ptr=0.
  - All outputs are 0: VALID=0, READY_out=0, Master=0, grant_active=0, payload=0.
  - Reset asserted mid-transaction drops the grant immediately; no handshake completes in that cycle.
- State machine: two states, IDLE and GRANT. The registered grant index g is valid only in GRANT.
- IDLE:
  - Outputs are zero.
  - If any VALID_in bit is set, the winner w is registered and the state moves to GRANT.
  - Latency is 1 cycle from request to VALID.
- Winner selection:
  - RR_MODE=0: highest set index.
  - RR_MODE=1: first set index scanning upward from rr_ptr, wrapping NUM_MASTERS-1 to 0.
- GRANT:
  - VALID = VALID_in[g]. Payload is the combinational mux of slice g. Master = g. grant_active = 1.
  - READY_out[g] = READY & VALID_in[g]; all other READY_out bits are 0.
  - Payload is never muxed from a non-granted master.
- Handshake (VALID & READY in GRANT):
  - RR_MODE=1: rr_ptr <= (g+1) mod NUM_MASTERS.
  - Next winner is computed from the current VALID_in using the updated pointer. In the same cycle VALID_in[g] may still be set for its next transaction, so only the pointer gives fairness.
  - If any request exists, the new grant is registered and the state stays GRANT (zero-bubble back-to-back). Otherwise go to IDLE.
- No handshake:
  - The grant holds while VALID_in[g]=1, regardless of higher-priority requests. There is no preemption.
- Granted master deasserts VALID without a handshake (AXI violation):
  - Return to IDLE next cycle; rr_ptr is unchanged.
- Single requester: the same master is regranted each handshake, one address per cycle when READY=1.
- All VALID_in set, RR_MODE=1: grants rotate 0,1,2,...,N-1,0 with one handshake each.
- Index arithmetic is modulo NUM_MASTERS; NUM_MASTERS need not be a power of 2.
- Wrap compares against NUM_MASTERS-1, not MIDX_W overflow.

Decomposition:
- Package axi_arb_pkg holds:
  - default width constants (ID/ADDR/LEN/SIZE/BURST);
  - the state enum (ARB_IDLE, ARB_GRANT);
  - mode constants ARB_FIXED=0 and ARB_RR=1.
- Sub-module rr_priority_picker: combinational, inputs req[N], ptr, mode; outputs idx and any. Shared with the future write-response arbiter.

Test Plan:
- Reset with VALID_in=4'b1111 held → all outputs 0 during reset; first grant Master=0 one cycle after release (RR, rr_ptr=0).
- RR, VALID_in=4'b1111 held, READY=1 → Master sequence 0,1,2,3,0 on consecutive cycles; exactly one READY_out bit per cycle.
- Fixed mode, VALID_in=4'b0101 with READY=1 → Master=2 every handshake; master 0 is never granted while master 2 requests.
- Grant on M1 with READY=0 for 5 cycles, M3 raises VALID at cycle 2 → Master stays 1, ADDR stays ADDR_in slice 1. After READY=1, next grant is M3.
- Granted M2 drops VALID without READY → VALID=0 and grant_active=0 next cycle; rr_ptr is unchanged, so the subsequent all-request pattern grants M2 first.
- Reset asserted while GRANT with READY=1 → no READY_out pulse that cycle; IDLE next cycle; NUM_MASTERS=3 wrap check 2→0.
